// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, types and reset-value helper for the register file
package rf_pkg;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 3;
    localparam int RF_DEPTH  = 1 << RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    // Each register resets to its own index so a post-reset dump is self-identifying.
    function automatic rf_data_t rf_reset_val(input int i);
        return rf_data_t'(i);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read mux, with write forwarding under RF_WRITE_BYPASS_EN
module rf_read_port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic                         bypass_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [DATA_W-1:0]            rd_data
);

`ifdef RF_WRITE_BYPASS_EN
    always_comb begin
        rd_data = regs[rd_addr];
        // Forward the write-back value so decode sees it in the same cycle.
        if (bypass_en && (rd_addr == wr_addr)) begin
            rd_data = wr_data;
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{bypass_en, wr_addr, wr_data};

    always_comb begin
        rd_data = regs[rd_addr];
    end
`endif

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 8x8 register file, two async read ports, one sync write port (option: RF_WRITE_BYPASS_EN)
module register_file
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] write_data,
    input  logic              WriteReg,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic                         wr_active;

    // A write coinciding with reset is dropped, so it must not be forwarded either.
    assign wr_active = WriteReg & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= DATA_W'(rf_reset_val(i));
            end
        end else if (WriteReg) begin
            regs[rd] <= write_data;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_read_port1 (
        .regs      (regs),
        .rd_addr   (rs1),
        .bypass_en (wr_active),
        .wr_addr   (rd),
        .wr_data   (write_data),
        .rd_data   (data1)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_read_port2 (
        .regs      (regs),
        .rd_addr   (rs2),
        .bypass_en (wr_active),
        .wr_addr   (rd),
        .wr_data   (write_data),
        .rd_data   (data2)
    );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - vector table plus scoreboard bench for register_file
module tb_register_file;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] rs1 = '0;
    logic [2:0] rs2 = '0;
    logic [2:0] rd = '0;
    logic [7:0] write_data = '0;
    logic       WriteReg = 1'b0;
    logic [7:0] data1;
    logic [7:0] data2;

    int checks = 0;
    int failures = 0;

    logic [7:0] model [8];

    typedef struct {
        logic       r;
        logic       we;
        logic [2:0] a;
        logic [7:0] d;
        logic [2:0] q1;
        logic [2:0] q2;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] e1;
        logic [7:0] e2;
    } exp_t;

    exp_t sb [$];
    vec_t vecs [8];

    register_file dut (
        .clk        (clk),
        .reset      (reset),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .write_data (write_data),
        .WriteReg   (WriteReg),
        .data1      (data1),
        .data2      (data2)
    );

    always #5 clk = ~clk;

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (data1 !== e.e1) begin
            failures++;
            $display("FAIL %s data1 got=%h want=%h", e.name, data1, e.e1);
        end
        checks++;
        if (data2 !== e.e2) begin
            failures++;
            $display("FAIL %s data2 got=%h want=%h", e.name, data2, e.e2);
        end
    endtask

    task automatic expect_now(input string name, input logic [7:0] e1, input logic [7:0] e2);
        exp_t e;
        e.name = name;
        e.e1 = e1;
        e.e2 = e2;
        sb.push_back(e);
        #1;
        compare_pop();
    endtask

    task automatic expect_read(input string name, input logic [2:0] a1, input logic [2:0] a2,
                               input logic [7:0] e1, input logic [7:0] e2);
        rs1 = a1;
        rs2 = a2;
        expect_now(name, e1, e2);
    endtask

    task automatic cycle(input logic r, input logic we, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        reset = r;
        WriteReg = we;
        rd = a;
        write_data = d;
        if (we) begin
            checks++;
            if ($isunknown(a)) begin
                failures++;
                $display("FAIL rd_unknown got=%b want=known", a);
            end
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) model[i] = 8'(i);
        end else if (we) begin
            model[a] = d;
        end
        #1;
        reset = 1'b0;
        WriteReg = 1'b0;
    endtask

    initial begin
        logic [7:0] bypass_exp;
        vecs[0] = '{1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd6, 8'h03, 8'h06};
        vecs[1] = '{1'b0, 1'b1, 3'd5, 8'h10, 3'd5, 3'd1, 8'h10, 8'h01};
        vecs[2] = '{1'b0, 1'b0, 3'd2, 8'hAA, 3'd2, 3'd5, 8'h02, 8'h10};
        vecs[3] = '{1'b1, 1'b1, 3'd5, 8'h20, 3'd5, 3'd2, 8'h05, 8'h02};
        vecs[4] = '{1'b0, 1'b1, 3'd7, 8'hFF, 3'd7, 3'd7, 8'hFF, 8'hFF};
        vecs[5] = '{1'b0, 1'b1, 3'd0, 8'h80, 3'd0, 3'd0, 8'h80, 8'h80};
        vecs[6] = '{1'b0, 1'b1, 3'd1, 8'h3C, 3'd1, 3'd0, 8'h3C, 8'h80};
        vecs[7] = '{1'b0, 1'b0, 3'd1, 8'h00, 3'd1, 3'd7, 8'h3C, 8'hFF};

        for (int i = 0; i < 8; i++) model[i] = 8'hxx;

        for (int v = 0; v < 8; v++) begin
            cycle(vecs[v].r, vecs[v].we, vecs[v].a, vecs[v].d);
            expect_read($sformatf("vec%0d", v), vecs[v].q1, vecs[v].q2, vecs[v].e1, vecs[v].e2);
        end

        // Reset sweep of every address through both ports.
        cycle(1'b1, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            expect_read($sformatf("reset_sweep%0d", i), 3'(i), 3'(7 - i), 8'(i), 8'(7 - i));
        end

        // Same-cycle read of the register being written.
        @(negedge clk);
        WriteReg = 1'b1;
        rd = 3'd3;
        write_data = 8'h5A;
        rs1 = 3'd3;
        rs2 = 3'd4;
`ifdef RF_WRITE_BYPASS_EN
        bypass_exp = 8'h5A;
`else
        bypass_exp = 8'h03;
`endif
        expect_now("same_cycle_pre", bypass_exp, 8'h04);
        @(posedge clk);
        model[3] = 8'h5A;
        #1;
        WriteReg = 1'b0;
        expect_now("same_cycle_post", 8'h5A, 8'h04);

        // A write held under reset must neither forward nor land.
        @(negedge clk);
        reset = 1'b1;
        WriteReg = 1'b1;
        rd = 3'd3;
        write_data = 8'h77;
        rs1 = 3'd3;
        rs2 = 3'd3;
        expect_now("reset_no_bypass", 8'h5A, 8'h5A);
        @(posedge clk);
        for (int i = 0; i < 8; i++) model[i] = 8'(i);
        #1;
        reset = 1'b0;
        WriteReg = 1'b0;
        expect_now("reset_drops_write", 8'h03, 8'h03);

        // Writes resume on the first edge after reset.
        cycle(1'b0, 1'b1, 3'd6, 8'hC3);
        expect_read("resume_write", 3'd6, 3'd5, 8'hC3, 8'h05);

        // Random writes against the reference model.
        for (int n = 0; n < 24; n++) begin
            cycle(1'b0, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom));
            begin
                logic [2:0] a1;
                logic [2:0] a2;
                a1 = 3'($urandom_range(0, 7));
                a2 = 3'($urandom_range(0, 7));
                expect_read($sformatf("rand%0d", n), a1, a2, model[a1], model[a2]);
            end
        end

        for (int i = 0; i < 8; i++) begin
            expect_read($sformatf("final_sweep%0d", i), 3'(i), 3'(i), model[i], model[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
